// File: rtl/iterative_shifter_if.sv
// Start/busy/done handshake and data bus between the shift-instruction control
// and the iterative shifter.
interface iterative_shifter_if #(
    parameter int DATA_WIDTH = 32
) ();
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

    logic                   start;
    logic [1:0]             op;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  out_data;

    modport master (
        output start, op, shamt, in_data,
        input  busy, done, out_data
    );

    modport slave (
        input  start, op, shamt, in_data,
        output busy, done, out_data
    );
endinterface

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROTR shifter: moves at most STEP bit positions per
// clock so only a (STEP+1)-way constant-shift mux is needed.
module iterative_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    iterative_shifter_if.slave bus
);
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [SHAMT_WIDTH:0] STEP_W = (SHAMT_WIDTH + 1)'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [DATA_WIDTH-1:0]  acc_r, acc_nxt_s;
    logic [SHAMT_WIDTH-1:0] rem_r, rem_nxt_s;
    logic [1:0]             op_r, op_nxt_s;
    logic [DATA_WIDTH-1:0]  out_r, out_nxt_s;
    logic                   busy_r, done_r;
    logic [SHAMT_WIDTH:0]   k_s;
    logic [DATA_WIDTH-1:0]  shifted_s;

    function automatic logic [DATA_WIDTH-1:0] shift_const(
        input logic [DATA_WIDTH-1:0] a,
        input logic [1:0]            m,
        input int                    j
    );
        logic [DATA_WIDTH-1:0] r;
        case (m)
            2'b00:   r = a << j;
            2'b01:   r = a >> j;
            2'b10:   r = DATA_WIDTH'($signed(a) >>> j);
            2'b11:   r = (a >> j) | (a << (DATA_WIDTH - j));
            default: r = a;
        endcase
        return r;
    endfunction

    // Each amount 1..STEP is a fixed wiring pattern; k selects one of them.
    function automatic logic [DATA_WIDTH-1:0] step_shift(
        input logic [DATA_WIDTH-1:0] a,
        input logic [1:0]            m,
        input logic [SHAMT_WIDTH:0]  k
    );
        logic [DATA_WIDTH-1:0] r;
        r = a;
        for (int j = 1; j <= STEP; j++) begin
            r = (k == (SHAMT_WIDTH + 1)'(j)) ? shift_const(a, m, j) : r;
        end
        return r;
    endfunction

    // Per-cycle shift amount and the shifted accumulator.
    always_comb begin
        k_s = STEP_W;
        if ({1'b0, rem_r} < STEP_W) begin
            k_s = {1'b0, rem_r};
        end else begin
            k_s = STEP_W;
        end
        shifted_s = step_shift(acc_r, op_r, k_s);
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        rem_nxt_s   = rem_r;
        op_nxt_s    = op_r;
        out_nxt_s   = out_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    acc_nxt_s = bus.in_data;
                    rem_nxt_s = bus.shamt;
                    op_nxt_s  = bus.op;
                    if (bus.shamt != '0) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_DONE;
                        out_nxt_s   = bus.in_data;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_nxt_s = shifted_s;
                rem_nxt_s = rem_r - k_s[SHAMT_WIDTH-1:0];
                if (rem_nxt_s == '0) begin
                    state_nxt_s = ST_DONE;
                    out_nxt_s   = shifted_s;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= '0;
            rem_r   <= '0;
            op_r    <= 2'b00;
            out_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            rem_r   <= rem_nxt_s;
            op_r    <= op_nxt_s;
            out_r   <= out_nxt_s;
            busy_r  <= (state_nxt_s == ST_SHIFT);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.out_data = out_r;
endmodule
